// File: rtl/vga_timing_pkg.sv
// Shared VGA raster timing constants and helpers for the test-pattern path.
package vga_timing_pkg;

    // Default 640x480@60 timing, in pixels (horizontal) and lines (vertical).
    localparam int unsigned DEF_H_ACTIVE  = 640;
    localparam int unsigned DEF_H_FP      = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BP      = 48;
    localparam int unsigned DEF_V_ACTIVE  = 480;
    localparam int unsigned DEF_V_FP      = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BP      = 33;
    localparam int unsigned DEF_BAR_WIDTH = 80;

    // Full period of one axis: active + front porch + sync + back porch.
    function automatic int unsigned axis_total(int unsigned active, int unsigned fp,
                                               int unsigned sync, int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    // First count value inside the sync pulse.
    function automatic int unsigned sync_start(int unsigned active, int unsigned fp);
        return active + fp;
    endfunction

    // First count value after the sync pulse (exclusive bound).
    function automatic int unsigned sync_end(int unsigned active, int unsigned fp,
                                             int unsigned sync);
        return active + fp + sync;
    endfunction

    // Bits needed to hold 0..max_val; never less than one.
    function automatic int unsigned cnt_width(int unsigned max_val);
        int unsigned w = 1;
        while ((max_val >> w) != 0) w++;
        return w;
    endfunction

endpackage

// File: rtl/vga_wrap_counter.sv
// Modulo (MAX+1) counter with clear and a same-cycle terminal-count pulse.
module vga_wrap_counter #(
    parameter int unsigned MAX   = 799,
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX);

    // Wrap flags the enabled step that returns the count to zero.
    assign wrap = en && (count == MAX_C);

    // Step on enable; clear and terminal count both return to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en) begin
            // NOTE: non-blocking, so every counter in the raster steps from the same pre-edge values.
            if (clr || count == MAX_C) count <= '0;
            else                       count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/vga_bar_index_gen.sv
// VGA raster timing plus a per-pixel colour-bar index for the 3-to-8 bar decoder.
module vga_bar_index_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
    parameter int unsigned H_FP      = DEF_H_FP,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BP      = DEF_H_BP,
    parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
    parameter int unsigned V_FP      = DEF_V_FP,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BP      = DEF_V_BP,
    parameter int unsigned BAR_WIDTH = DEF_BAR_WIDTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_ce,
    input  logic       scroll,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       bar_en,
    output logic [2:0] bar_index,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned HW      = cnt_width(H_TOTAL - 1);
    localparam int unsigned VW      = cnt_width(V_TOTAL - 1);
    localparam int unsigned BPW     = cnt_width(BAR_WIDTH - 1);

    localparam logic [HW-1:0] H_ACT_C    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START_C = HW'(sync_start(H_ACTIVE, H_FP));
    localparam logic [HW-1:0] HS_END_C   = HW'(sync_end(H_ACTIVE, H_FP, H_SYNC));
    localparam logic [VW-1:0] V_ACT_C    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START_C = VW'(sync_start(V_ACTIVE, V_FP));
    localparam logic [VW-1:0] VS_END_C   = VW'(sync_end(V_ACTIVE, V_FP, V_SYNC));

    logic [HW-1:0]  h_cnt;
    logic [VW-1:0]  v_cnt;
    logic [BPW-1:0] bar_px_unused;  // position within a bar; only its wrap is consumed
    logic           h_wrap;
    logic           v_wrap;
    logic           bar_wrap;
    logic [2:0]     bar_cnt;
    logic [2:0]     offset;
    logic           active;
    logic           in_hsync;
    logic           in_vsync;

    vga_wrap_counter #(.MAX(H_TOTAL - 1), .WIDTH(HW)) u_h_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pix_ce),
        .clr   (1'b0),
        .count (h_cnt),
        .wrap  (h_wrap)
    );

    // The line wrap is the only event that advances the line counter.
    vga_wrap_counter #(.MAX(V_TOTAL - 1), .WIDTH(VW)) u_v_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (h_wrap),
        .clr   (1'b0),
        .count (v_cnt),
        .wrap  (v_wrap)
    );

    // Pixel-within-bar counter, re-aligned to zero at every line start.
    vga_wrap_counter #(.MAX(BAR_WIDTH - 1), .WIDTH(BPW)) u_bar_px (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pix_ce),
        .clr   (h_wrap),
        .count (bar_px_unused),
        .wrap  (bar_wrap)
    );

    assign active   = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    assign in_hsync = (h_cnt >= HS_START_C) && (h_cnt < HS_END_C);
    assign in_vsync = (v_cnt >= VS_START_C) && (v_cnt < VS_END_C);

    // Bar number steps once per bar width and restarts at each line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bar_cnt <= '0;
        end else if (pix_ce) begin
            if (h_wrap)        bar_cnt <= '0;
            else if (bar_wrap) bar_cnt <= bar_cnt + 3'd1;
        end
    end

    // Scroll is sampled only on the frame wrap; the offset is never cleared by it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            offset <= '0;
        end else if (v_wrap && scroll) begin
            offset <= offset + 3'd1;
        end
    end

    // Outputs decode the pre-step counters, so they trail the raster by one pixel step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_n     <= 1'b1;
            vsync_n     <= 1'b1;
            bar_en      <= 1'b0;
            bar_index   <= '0;
            frame_start <= 1'b0;
        end else if (pix_ce) begin
            hsync_n     <= !in_hsync;
            vsync_n     <= !in_vsync;
            bar_en      <= active;
            bar_index   <= active ? (bar_cnt + offset) : 3'd0;
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end else begin
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_bar_index_gen.sv
// Randomised and directed bench for vga_bar_index_gen against a flat pixel-index model.
module tb_vga_bar_index_gen;

    // Reduced raster so many frames fit in a short run; ten bars per line exercise the mod-8 wrap.
    localparam int HA = 40, HFP = 4, HS = 6, HBP = 5;
    localparam int VA = 12, VFP = 2, VS = 2, VBP = 3;
    localparam int BW = 4;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam logic [6:0] RST_OUT   = 7'b1100000;  // {hsync_n,vsync_n,bar_en,bar_index,frame_start}
    localparam logic [6:0] FIRST_OUT = 7'b1110001;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       pix_ce = 1'b0;
    logic       scroll = 1'b0;
    logic       hsync_n, vsync_n, bar_en, frame_start;
    logic [2:0] bar_index;

    int n_checks = 0;
    int n_errors = 0;

    vga_bar_index_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .BAR_WIDTH(BW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_ce      (pix_ce),
        .scroll      (scroll),
        .hsync_n     (hsync_n),
        .vsync_n     (vsync_n),
        .bar_en      (bar_en),
        .bar_index   (bar_index),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {hsync_n, vsync_n, bar_en, bar_index, frame_start};
    endfunction

    // Expected outputs for flat pixel position p within a frame and a bar offset.
    function automatic logic [6:0] model_out(int p, int off);
        int   h = p % HT;
        int   v = p / HT;
        logic en = (h < HA) && (v < VA);
        logic [2:0] idx = en ? 3'((h / BW + off) % 8) : 3'd0;
        logic hs = !((h >= HA + HFP) && (h < HA + HFP + HS));
        logic vs = !((v >= VA + VFP) && (v < VA + VFP + VS));
        return {hs, vs, en, idx, p == 0};
    endfunction

    // Reference: next pixel position, bar offset, and the outputs expected after each edge.
    int         m_p;
    int         m_off;
    logic [6:0] m_out;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_p   <= 0;
            m_off <= 0;
            m_out <= RST_OUT;
        end else if (pix_ce) begin
            m_out <= model_out(m_p, m_off);
            m_p   <= (m_p == FRAME - 1) ? 0 : m_p + 1;
            if (m_p == FRAME - 1 && scroll) m_off <= (m_off + 1) % 8;
        end else begin
            m_out <= {m_out[6:1], 1'b0};
        end
    end

    // Every cycle, compare all outputs with the model on the inactive clock edge.
    always @(negedge clk) check("pixel", 32'(outs()), 32'(m_out));

    // One clock with the given pixel enable; returns just after the following falling edge.
    task automatic tick(input logic ce);
        pix_ce = ce;
        @(negedge clk);
        #1;
    endtask

    // mode 0: continuous, 1: one-in-two, 2: random with random scroll flips.
    task automatic run(input int cycles, input int mode);
        for (int i = 0; i < cycles; i++) begin
            if (mode == 2 && $urandom_range(0, 199) == 0) scroll = ~scroll;
            case (mode)
                0:       tick(1'b1);
                1:       tick(1'(i % 2 == 0));
                default: tick(1'($urandom_range(0, 2) != 0));
            endcase
        end
    endtask

    // Step continuously until the model is about to present position target.
    task automatic run_to(input int target);
        int guard = 0;
        while (m_p != target && guard < 2 * FRAME) begin
            tick(1'b1);
            guard++;
        end
        if (m_p != target) check("wait_pos", 32'(m_p), 32'(target));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        tick(1'b0);
        tick(1'b0);
    endtask

    initial begin
        int ticks, hs_low, hs_first, vs_low, en_cnt;

        #1;
        @(negedge clk);
        #1;
        do_reset();

        // Reset, first pixel and the bar boundaries on the first line.
        check("reset_outs", 32'(outs()), 32'(RST_OUT));
        tick(1'b1);
        check("first_pixel", 32'(outs()), 32'(FIRST_OUT));
        for (int k = 1; k <= HA; k++) begin
            tick(1'b1);
            if (k == BW - 1) check("last_px_bar0", 32'(bar_index), 32'd0);
            if (k == BW)     check("first_px_bar1", 32'(bar_index), 32'd1);
            if (k == HA - 1) check("last_active_idx", 32'(bar_index), 32'(((HA - 1) / BW) % 8));
            if (k == HA)     check("blank_en_idx", 32'({bar_en, bar_index}), 32'd0);
        end

        // Sync widths, active-pixel count and frame period over one full frame.
        ticks = 0;
        while (!frame_start && ticks < 2 * FRAME) begin
            tick(1'b1);
            ticks++;
        end
        check("frame_start_seen", 32'(frame_start), 32'd1);
        hs_low   = !hsync_n ? 1 : 0;
        hs_first = -1;
        vs_low   = !vsync_n ? 1 : 0;
        en_cnt   = bar_en ? 1 : 0;
        ticks    = 0;
        while (ticks < 2 * FRAME) begin
            tick(1'b1);
            ticks++;
            if (frame_start) break;
            if (ticks < HT && !hsync_n) begin
                hs_low++;
                if (hs_first < 0) hs_first = ticks;
            end
            if (!vsync_n) vs_low++;
            if (bar_en) en_cnt++;
        end
        check("frame_period", 32'(ticks), 32'(FRAME));
        check("hsync_width", 32'(hs_low), 32'(HS));
        check("hsync_first", 32'(hs_first), 32'(HA + HFP));
        check("vsync_steps", 32'(vs_low), 32'(VS * HT));
        check("active_pixels", 32'(en_cnt), 32'(HA * VA));

        // Scroll for nine frames, then drop it mid-frame.
        scroll = 1'b1;
        run(9 * FRAME, 0);
        run(FRAME / 2, 0);
        scroll = 1'b0;
        run(2 * FRAME + 10, 0);

        // Half-rate pixel enable, then a long stall in the middle of a line.
        run(2 * FRAME, 1);
        run_to(3 * HT + 20);
        run(37, 3'd1 == 3'd0 ? 0 : 1);
        for (int i = 0; i < 37; i++) tick(1'b0);
        run(2 * FRAME, 1);

        // Random pixel enable with random scroll changes.
        run(3 * FRAME, 2);
        scroll = 1'b0;

        // Asynchronous reset mid-frame, then restart at (0,0).
        run_to(7 * HT + 23);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 32'(outs()), 32'(RST_OUT));
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        tick(1'b0);
        tick(1'b1);
        check("restart_pixel", 32'(outs()), 32'(FIRST_OUT));
        run(HT, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
